datapath_sequencer: RTL

Command-level controller for the 8-bit datapath (register file plus ALU). It accepts operation commands `{alu_op, operand1, operand2}` through a valid/ready handshake and buffers them in a small FIFO. For each command it drives the datapath's operand buses, load strobes and ALU opcode in a fixed three-cycle sequence, then returns the result and flags with a one-cycle `done` pulse. It sits between the instruction decode/control logic and the `datapath` instance.

---
 rtl/dp_seq_pkg.sv | 20 ++
 rtl/dp_cmd_fifo.sv | 50 +++++
 rtl/datapath_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dp_seq_pkg.sv
// Shared types for the datapath sequencer: FSM states, the queued command word,
// and the LOAD-to-CAPTURE sequence length.
package dp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC,
    CAPTURE
  } dp_seq_state_t;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } dp_cmd_t;

  localparam int unsigned DP_SEQ_LATENCY = 3;

endpackage

// File: rtl/dp_cmd_fifo.sv
// Synchronous command FIFO of dp_cmd_t; DEPTH must be a power of two (>= 2).
// Head is read combinationally; simultaneous push and pop are both honoured.
module dp_cmd_fifo
  import dp_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    push,
  input  dp_cmd_t push_data,
  input  logic    pop,
  output dp_cmd_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  dp_cmd_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Command sequencer for the 8-bit register-file/ALU datapath: queues {op,a,b} commands and
// runs each as LOAD/EXEC/CAPTURE. Define DP_SEQ_FLAG_CAPTURE_EN to latch dp_flags into rsp_flags.
module datapath_sequencer
  import dp_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [7:0] dp_operando1,
  output logic [7:0] dp_operando2,
  output logic [7:0] dp_alu_op,
  output logic       dp_load_a,
  output logic       dp_load_b,
  output logic       dp_load_c,
  input  logic [7:0] dp_result,
  input  logic [7:0] dp_flags,
  output logic [7:0] rsp_result,
  output logic [7:0] rsp_flags,
  output logic       done,
  output logic       busy
);

  dp_seq_state_t state;
  dp_cmd_t       cur;
  dp_cmd_t       head;
  dp_cmd_t       incoming;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;
  // CAPTURE pops too, so a queued command follows without an IDLE bubble.
  assign pop       = !empty && ((state == IDLE) || (state == CAPTURE));
  assign incoming  = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign busy      = (state != IDLE);

  dp_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(incoming),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      done       <= 1'b0;
      rsp_result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur   <= head;
            state <= LOAD;
          end
        end
        LOAD:    state <= EXEC;
        EXEC:    state <= CAPTURE;
        CAPTURE: begin
          rsp_result <= dp_result;
          done       <= 1'b1;
          if (pop) begin
            cur   <= head;
            state <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath controls decode from the state register and the held command.
  always_comb begin
    dp_operando1 = '0;
    dp_operando2 = '0;
    dp_load_a    = 1'b0;
    dp_load_b    = 1'b0;
    dp_load_c    = 1'b0;
    dp_alu_op    = '0;
    if (state == LOAD) begin
      dp_operando1 = cur.a;
      dp_operando2 = cur.b;
      dp_load_a    = 1'b1;
      dp_load_b    = 1'b1;
    end
    if (state == EXEC) begin
      dp_load_c = 1'b1;
    end
    if (state != IDLE) begin
      dp_alu_op = cur.op;
    end
  end

`ifdef DP_SEQ_FLAG_CAPTURE_EN
  logic [7:0] flags_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      flags_q <= '0;
    end else if (state == CAPTURE) begin
      flags_q <= dp_flags;
    end
  end

  assign rsp_flags = flags_q;
`else
  logic flags_unused;

  assign flags_unused = ^dp_flags;
  assign rsp_flags    = '0;
`endif

endmodule
